// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: the carry chain is cut into STAGES equal segments,
// one register per segment, with a valid/ready handshake that freezes the whole pipe on backpressure.
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Returns {carry into segment MSB, carry out of segment, segment sum bits}.
    function automatic logic [SEG+1:0] ripple_seg(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           c
    );
        logic [SEG:0]   carry;
        logic [SEG-1:0] s;
        carry    = {(SEG+1){1'b0}};
        s        = {SEG{1'b0}};
        carry[0] = c;
        for (int i = 0; i < SEG; i++) begin
            s[i]       = x[i] ^ y[i] ^ carry[i];
            carry[i+1] = (x[i] & y[i]) | ((x[i] | y[i]) & carry[i]);
        end
        return {carry[SEG-1], carry[SEG], s};
    endfunction

    logic             advance_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             ovf_r;
    logic             zero_r;

    // Subtraction only inverts b; any +1 comes from cin.
    always_comb begin
        if (sub) begin
            b_eff_s = ~b;
        end else begin
            b_eff_s = b;
        end
    end

    // Each stage word carries finished result bits below its segment and raw operand bits above it.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vld_r;
        logic             cy_r;
        logic [WIDTH-1:0] x_r;
        logic [WIDTH-1:0] y_r;
        logic             src_v_s;
        logic             src_c_s;
        logic [WIDTH-1:0] src_x_s;
        logic [WIDTH-1:0] src_y_s;
        logic [SEG+1:0]   seg_s;
        logic [WIDTH-1:0] nxt_x_s;

        if (k == 0) begin : g_src
            assign src_v_s = in_valid;
            assign src_c_s = cin;
            assign src_x_s = a;
            assign src_y_s = b_eff_s;
        end else begin : g_src
            assign src_v_s = g_stage[k-1].vld_r;
            assign src_c_s = g_stage[k-1].cy_r;
            assign src_x_s = g_stage[k-1].x_r;
            assign src_y_s = g_stage[k-1].y_r;
        end

        // Ripple this stage's segment and splice the sum bits over the consumed operand bits.
        always_comb begin
            seg_s                 = ripple_seg(src_x_s[k*SEG +: SEG], src_y_s[k*SEG +: SEG], src_c_s);
            nxt_x_s               = src_x_s;
            nxt_x_s[k*SEG +: SEG] = seg_s[SEG-1:0];
        end

        // Stage register: cleared by reset, loaded on advance, otherwise held with its valid bit.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_r <= 1'b0;
                cy_r  <= 1'b0;
                x_r   <= {WIDTH{1'b0}};
                y_r   <= {WIDTH{1'b0}};
            end else if (advance_s) begin
                vld_r <= src_v_s;
                cy_r  <= seg_s[SEG];
                x_r   <= nxt_x_s;
                y_r   <= src_y_s;
            end
        end

        if (k == LAST) begin : g_flags
            // Flags are registered with the final segment so they hold with the result during a stall.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (advance_s) begin
                    ovf_r  <= seg_s[SEG+1] ^ seg_s[SEG];
                    zero_r <= ~|nxt_x_s;
                end
            end
        end
    end

    // The pipe moves as one; it freezes only while a finished beat waits for the consumer.
    always_comb begin
        advance_s = ~g_stage[LAST].vld_r | out_ready;
    end

    assign in_ready  = advance_s;
    assign out_valid = g_stage[LAST].vld_r;
    assign sum       = {g_stage[LAST].cy_r, g_stage[LAST].x_r};
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed corner cases, back-to-back traffic,
// random backpressure and reset with operations in flight.
module tb_pipelined_addsub;

    localparam int W = 64;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   sum;
    logic         ovf;
    logic         zero;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int pop_count = 0;
    int accepted  = 0;

    logic [W+2:0] exp_q[$];
    int           pop_cyc[$];
    logic         rst_at_edge = 1'b1;
    logic         held = 1'b0;
    logic [W+2:0] held_val = '0;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    // Reference: plain wide arithmetic, {ovf, zero, sum}.
    function automatic logic [W+2:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                           input logic c, input logic s);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         o;
        logic         z;
        be   = s ? ~bb : bb;
        full = {1'b0, aa} + {1'b0, be} + {{W{1'b0}}, c};
        o    = (aa[W-1] == be[W-1]) && (full[W-1] != aa[W-1]);
        z    = (full[W-1:0] == {W{1'b0}});
        return {o, z, full};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop on handshake, stability check while stalled.
    always @(negedge clk) begin
        if (held && !rst_at_edge) begin
            check("stall_hold", {out_valid, ovf, zero, sum}, {1'b1, held_val});
        end
        if (out_valid && out_ready) begin
            check("output_expected", 128'(exp_q.size() > 0), 128'd1);
            if (exp_q.size() > 0) begin
                check("result", {ovf, zero, sum}, exp_q.pop_front());
                pop_count++;
                pop_cyc.push_back(cyc);
            end
        end
        held     = out_valid && !out_ready;
        held_val = {ovf, zero, sum};
    end

    task automatic drive(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic c, input logic s, input logic ordy);
        in_valid  = v;
        a         = aa;
        b         = bb;
        cin       = c;
        sub       = s;
        out_ready = ordy;
        @(negedge clk);
        if (v && in_ready) begin
            exp_q.push_back(model(aa, bb, c, s));
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        repeat (n) drive(1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0, ordy);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            drive(1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        check(tag, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic run_single(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                              input logic c, input logic s,
                              input logic [W:0] es, input logic eo, input logic ez);
        int lat;
        drive(1'b1, aa, bb, c, s, 1'b1);
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 4 * S + 8) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(S));
        check({tag, "_sum"}, 128'(sum), 128'(es));
        check({tag, "_ovf"}, 128'(ovf), 128'(eo));
        check({tag, "_zero"}, 128'(zero), 128'(ez));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int c0;
        int a0;
        int span;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = {W{1'b0}};
        b         = {W{1'b0}};
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_sum", 128'(sum), 128'd0);
        check("reset_ovf", 128'(ovf), 128'd0);
        check("reset_zero", 128'(zero), 128'd0);
        check("reset_in_ready", 128'(in_ready), 128'd1);
        rst = 1'b0;

        // Directed corner cases
        run_single("t1_carry_out", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                   65'h1_0000_0000_0000_0000, 1'b0, 1'b1);
        run_single("t2_sub_borrow", 64'h5, 64'h7, 1'b1, 1'b1,
                   {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b0, 1'b0);
        run_single("t3_pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                   {1'b0, 64'h8000_0000_0000_0000}, 1'b1, 1'b0);
        run_single("t3_neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                   65'h1_0000_0000_0000_0000, 1'b1, 1'b1);
        run_single("sub_no_cin", 64'hA, 64'h3, 1'b0, 1'b1,
                   65'h1_0000_0000_0000_0006, 1'b0, 1'b0);
        run_single("sub_equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1,
                   65'h1_0000_0000_0000_0000, 1'b0, 1'b1);

        // Back-to-back: 100 ops, one result per cycle
        p0 = pop_count;
        c0 = pop_cyc.size();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        drain("t4_drain");
        check("t4_count", 128'(pop_count - p0), 128'd100);
        span = (pop_cyc.size() >= c0 + 100) ? pop_cyc[c0 + 99] - pop_cyc[c0] : -1;
        check("t4_one_per_cycle", 128'(span), 128'd99);

        // Backpressure: stalled output holds and blocks input
        c0 = pop_cyc.size();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'(i), 1'b0);
        end
        idle(6, 1'b0);
        check("stall_out_valid", 128'(out_valid), 128'd1);
        check("stall_in_ready", 128'(in_ready), 128'd0);
        a0 = accepted;
        drive(1'b1, 64'h1, 64'h2, 1'b0, 1'b0, 1'b0);
        check("stall_no_accept", 128'(accepted - a0), 128'd0);
        drain("stall_drain");
        span = (pop_cyc.size() >= c0 + 3) ? pop_cyc[c0 + 2] - pop_cyc[c0] : -1;
        check("stall_release_span", 128'(span), 128'd2);

        // Random in_valid (70%) and out_ready (50%)
        p0 = pop_count;
        a0 = accepted;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 70), {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain("t5_drain");
        check("t5_no_loss", 128'(pop_count - p0), 128'(accepted - a0));

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("t6_out_valid", 128'(out_valid), 128'd0);
        check("t6_sum", 128'(sum), 128'd0);
        check("t6_flags", {126'd0, ovf, zero}, 128'd0);
        rst = 1'b0;
        p0 = pop_count;
        idle(12, 1'b1);
        check("t6_no_stale", 128'(pop_count - p0), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
